inst_mem: RTL

Parametrised instruction memory for the single-cycle/multi-cycle MIPS cores: a synchronous-read word store with a fetch request/valid handshake, out-of-range detection, and a byte-serial boot-load port that rewrites the program at run time. It sits between the PC/fetch stage and the UART boot loader. Contents survive reset, so a program can be loaded once and re-run by resetting the core.

---
 rtl/inst_mem.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/inst_mem.sv
// Instruction memory: synchronous-read word store with a fetch handshake and a byte-serial boot-load port.
// Latency: a fetch accepted in cycle N returns data and error in N+1, with one fetch per cycle sustained.
// Backpressure: fetch_ready drops while a load is in progress, and fetches offered during a load are dropped.
//
// Ports:
//   clk, reset_n                      clock and asynchronous active-low reset
//   fetch_req/fetch_addr/fetch_ready  fetch request; byte address, low log2(BPW) bits ignored
//   fetch_valid/fetch_data/fetch_err  one-cycle result pulse; data and error hold until the next fetch
//   load_start/load_abort             begin a reload at word 0 / abandon the load in progress
//   load_valid/load_byte              program byte stream, big-endian within each word
//   load_busy/load_done               load in progress / one-cycle pulse after the last word is written
//
// Optional feature: define IMEM_LOAD_EN to compile in the load port, the RUN/LOAD FSM and the writable
// store. Without it the load inputs are ignored and the contents stay at their power-up value (zero).
// Memory contents are never cleared by reset, so a loaded program survives a core reset.

module inst_mem #(
  parameter int DEPTH  = 32,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_ready,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_abort,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_busy,
  output logic              load_done
);

  localparam int BPW  = DATA_W / 8;
  localparam int OFF  = (BPW > 1) ? $clog2(BPW) : 0;
  localparam int WP_W = $clog2(DEPTH);
  localparam int BC_W = (BPW > 1) ? $clog2(BPW) : 1;
  // One bit wider than the address so that DEPTH*BPW == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH * BPW);

  logic              fetch_acc;
  logic              in_range;
  logic [WP_W-1:0]   word_idx;
  logic [DATA_W-1:0] rd_word;

  assign fetch_acc = fetch_req && fetch_ready;
  assign in_range  = {1'b0, fetch_addr} < LIMIT;
  assign word_idx  = WP_W'(fetch_addr >> OFF);

`ifdef IMEM_LOAD_EN
  typedef enum logic {RUN, LOAD} state_t;

  state_t            state_q, state_d;
  logic [WP_W-1:0]   wp_q, wp_d;
  logic [BC_W-1:0]   bc_q, bc_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic              done_q, done_d;
  logic              mem_we;
  logic [DATA_W-1:0] word_next;
  logic [DATA_W-1:0] mem [DEPTH];

  // Shift the new byte in at the bottom so the first byte of a word ends up in the top lane.
  assign word_next = DATA_W'({asm_q, load_byte});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      wp_q    <= '0;
      bc_q    <= '0;
      asm_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      bc_q    <= bc_d;
      asm_q   <= asm_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wp_d        = wp_q;
    bc_d        = bc_q;
    asm_d       = asm_q;
    done_d      = 1'b0;
    mem_we      = 1'b0;
    fetch_ready = 1'b0;
    load_busy   = 1'b0;
    case (state_q)
      RUN: begin
        fetch_ready = 1'b1;
        if (load_start) begin
          state_d = LOAD;
          wp_d    = '0;
          bc_d    = '0;
          asm_d   = '0;
        end
      end
      LOAD: begin
        load_busy = 1'b1;
        // Abort wins over a byte that would complete a word in the same cycle.
        if (load_abort) begin
          state_d = RUN;
          bc_d    = '0;
        end else if (load_valid) begin
          asm_d = word_next;
          if (bc_q == BC_W'(BPW - 1)) begin
            mem_we = 1'b1;
            bc_d   = '0;
            if (wp_q == WP_W'(DEPTH - 1)) begin
              wp_d    = '0;
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              wp_d = wp_q + 1'b1;
            end
          end else begin
            bc_d = bc_q + 1'b1;
          end
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Storage has no reset so a loaded program survives a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wp_q] <= word_next;
  end

  assign rd_word   = mem[word_idx];
  assign load_done = done_q;
`else
  logic unused_load;

  assign unused_load = ^{load_start, load_abort, load_valid, load_byte, word_idx};
  assign rd_word     = '0;
  assign fetch_ready = 1'b1;
  assign load_busy   = 1'b0;
  assign load_done   = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_err   <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fetch_data <= in_range ? rd_word : '0;
        fetch_err  <= !in_range;
      end
    end
  end

endmodule
